lk_grad_accum: RTL

//  Consumes the 3-row column stream from the windowed image FIFO (top/mid/bottom pixel per beat) and

---
 rtl/lk_grad_accum.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lk_grad_accum.sv
// Structure-tensor accumulator for Lucas-Kanade: central-difference gradients from a
// 3-row column stream, then Sxx/Syy/Sxy summed over one WIN_COLS x WIN_ROWS window.
module lk_grad_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_COLS   = 7,
  parameter int WIN_ROWS   = 5,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  win_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pix_top,
  input  logic [DATA_WIDTH-1:0] pix_mid,
  input  logic [DATA_WIDTH-1:0] pix_bot,
  output logic                  grad_valid,
  output logic [DATA_WIDTH:0]   grad_ix,
  output logic [DATA_WIDTH:0]   grad_iy,
  output logic                  sum_valid,
  output logic [ACC_WIDTH-1:0]  sum_xx,
  output logic [ACC_WIDTH-1:0]  sum_yy,
  output logic [ACC_WIDTH-1:0]  sum_xy,
  output logic                  busy
);

  localparam int GW = DATA_WIDTH + 1;
  localparam int PW = 2 * GW;
  localparam int CW = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
  localparam int SW = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(WIN_COLS - 1);
  localparam logic [SW-1:0] STRIP_LAST = SW'(WIN_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0] r_col;
  logic [SW-1:0] r_strip;
  // Index 0 is the newest column. Only the centre column of top/bot is needed for Iy,
  // so those rows keep two columns; mid keeps three for the c+1 / c-1 difference.
  logic [1:0][DATA_WIDTH-1:0] r_top, r_bot;
  logic [2:0][DATA_WIDTH-1:0] r_mid;

  logic [2:0] r_vld_pipe;
  logic [3:0] r_last_pipe;
  logic signed [GW-1:0] r_ix, r_iy;
  logic signed [PW-1:0] r_pxx, r_pyy, r_pxy;
  logic signed [ACC_WIDTH-1:0] r_axx, r_ayy, r_axy;
  logic signed [ACC_WIDTH-1:0] w_add_xx, w_add_yy, w_add_xy;
  logic signed [ACC_WIDTH-1:0] w_base_xx, w_base_yy, w_base_xy;
  logic [ACC_WIDTH-1:0] r_sxx, r_syy, r_sxy;
  logic r_sum_vld;

  logic w_pt, w_beat_last, w_done;

  assign w_pt        = in_valid && (r_col >= CW'(2));
  assign w_beat_last = in_valid && (r_col == COL_LAST) && (r_strip == STRIP_LAST);
  assign w_done      = r_last_pipe[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_strip <= '0;
      r_top   <= '0;
      r_mid   <= '0;
      r_bot   <= '0;
    end else if (win_start) begin
      // A beat alongside win_start is column 0 of the new window.
      r_col   <= in_valid ? CW'(1) : '0;
      r_strip <= '0;
      r_top   <= in_valid ? {{DATA_WIDTH{1'b0}}, pix_top} : '0;
      r_bot   <= in_valid ? {{DATA_WIDTH{1'b0}}, pix_bot} : '0;
      r_mid   <= in_valid ? {{(2*DATA_WIDTH){1'b0}}, pix_mid} : '0;
    end else if (in_valid) begin
      r_top <= {r_top[0], pix_top};
      r_bot <= {r_bot[0], pix_bot};
      r_mid <= {r_mid[1:0], pix_mid};
      if (r_col == COL_LAST) begin
        r_col   <= '0;
        r_strip <= (r_strip == STRIP_LAST) ? '0 : r_strip + SW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (win_start) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[1:0], w_pt};
      r_last_pipe <= {r_last_pipe[2:0], w_beat_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ix  <= '0;
      r_iy  <= '0;
      r_pxx <= '0;
      r_pyy <= '0;
      r_pxy <= '0;
    end else begin
      if (r_vld_pipe[0]) begin
        r_ix <= $signed({1'b0, r_mid[0]}) - $signed({1'b0, r_mid[2]});
        r_iy <= $signed({1'b0, r_bot[1]}) - $signed({1'b0, r_top[1]});
      end
      if (r_vld_pipe[1]) begin
        r_pxx <= r_ix * r_ix;
        r_pyy <= r_iy * r_iy;
        r_pxy <= r_ix * r_iy;
      end
    end
  end

  // On the completion cycle the bank restarts from the point arriving now, so a
  // back-to-back window's first product is never lost.
  always_comb begin
    w_add_xx  = r_vld_pipe[2] ? ACC_WIDTH'(r_pxx) : '0;
    w_add_yy  = r_vld_pipe[2] ? ACC_WIDTH'(r_pyy) : '0;
    w_add_xy  = r_vld_pipe[2] ? ACC_WIDTH'(r_pxy) : '0;
    w_base_xx = w_done ? '0 : r_axx;
    w_base_yy = w_done ? '0 : r_ayy;
    w_base_xy = w_done ? '0 : r_axy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_axx <= '0;
      r_ayy <= '0;
      r_axy <= '0;
    end else if (win_start) begin
      r_axx <= '0;
      r_ayy <= '0;
      r_axy <= '0;
    end else begin
      r_axx <= w_base_xx + w_add_xx;
      r_ayy <= w_base_yy + w_add_yy;
      r_axy <= w_base_xy + w_add_xy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_vld <= 1'b0;
      r_sxx     <= '0;
      r_syy     <= '0;
      r_sxy     <= '0;
    end else begin
      r_sum_vld <= w_done && !win_start;
      if (w_done && !win_start) begin
        r_sxx <= r_axx;
        r_syy <= r_ayy;
        r_sxy <= r_axy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (win_start) begin
      w_state_nxt = in_valid ? RUN : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nxt = RUN;
        RUN:     if (w_beat_last) w_state_nxt = FLUSH;
        FLUSH:   if (w_done) begin
                   // Beats already taken during the flush belong to the next window.
                   w_state_nxt = (in_valid || r_col != '0 || r_strip != '0) ? RUN : IDLE;
                 end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign grad_valid = r_vld_pipe[1];
  assign grad_ix    = r_ix;
  assign grad_iy    = r_iy;
  assign sum_valid  = r_sum_vld;
  assign sum_xx     = r_sxx;
  assign sum_yy     = r_syy;
  assign sum_xy     = r_sxy;
  assign busy       = (r_state != IDLE);

endmodule
